// File: rtl/exec_trace_buffer.sv
// exec_trace_buffer
//   Captures retired-instruction samples {pc, alu_out, alu_op, branch} into a
//   small ring buffer, stops after an optional PC-match trigger plus a number
//   of post-trigger samples (or when full in one-shot mode), then presents the
//   stored entries oldest-first through a valid/ready read port.
//
// Ports
//   clk, rst            clock; synchronous active-low reset
//   arm, abort          start capture (IDLE only); return to IDLE from anywhere
//   trig_en, trig_pc    PC-match trigger enable and compare value
//   in_valid, in_pc, in_alu_out, in_alu_op, in_branch   sample input
//   rd_ready            consumer accepts the presented entry
//   rd_valid, rd_pc, rd_alu_out, rd_alu_op, rd_branch   oldest entry (zero when idle)
//   state               0 IDLE, 1 ARMED, 2 POST, 3 READOUT
//   count               stored entries, 0..DEPTH
//   overflow            an entry was overwritten during this capture
module exec_trace_buffer #(
   parameter int XLEN      = 32,
   parameter int DEPTH     = 16,
   parameter int POST_TRIG = 4,
   parameter int MODE      = 0,
   localparam int AW       = $clog2(DEPTH),
   localparam int CW       = AW + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            arm,
   input  logic            abort,
   input  logic            trig_en,
   input  logic [XLEN-1:0] trig_pc,
   input  logic            in_valid,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_alu_out,
   input  logic [3:0]      in_alu_op,
   input  logic            in_branch,
   input  logic            rd_ready,
   output logic            rd_valid,
   output logic [XLEN-1:0] rd_pc,
   output logic [XLEN-1:0] rd_alu_out,
   output logic [3:0]      rd_alu_op,
   output logic            rd_branch,
   output logic [1:0]      state,
   output logic [CW-1:0]   count,
   output logic            overflow
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARMED   = 2'd1,
      S_POST    = 2'd2,
      S_READOUT = 2'd3
   } state_t;

   state_t          r_state,  w_state_nxt;
   logic [AW-1:0]   r_wr_ptr, w_wr_ptr_nxt;
   logic [CW-1:0]   r_count,  w_count_nxt;
   logic [CW-1:0]   r_post,   w_post_nxt;
   logic            r_overflow, w_overflow_nxt;
   logic            w_we;
   logic            w_trig;
   logic            w_fills;
   logic            w_rd_valid;
   logic [AW-1:0]   w_rd_idx;

   logic [XLEN-1:0] r_mem_pc  [DEPTH];
   logic [XLEN-1:0] r_mem_alu [DEPTH];
   logic [3:0]      r_mem_op  [DEPTH];
   logic            r_mem_br  [DEPTH];

   assign w_trig  = (r_state == S_ARMED) && trig_en && in_valid && (in_pc == trig_pc);
   // One-shot capture: this write is the one that makes the buffer full.
   assign w_fills = (MODE == 1) && (r_count == CW'(DEPTH - 1));

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_wr_ptr   <= '0;
         r_count    <= '0;
         r_post     <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_wr_ptr   <= w_wr_ptr_nxt;
         r_count    <= w_count_nxt;
         r_post     <= w_post_nxt;
         r_overflow <= w_overflow_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_wr_ptr_nxt   = r_wr_ptr;
      w_count_nxt    = r_count;
      w_post_nxt     = r_post;
      w_overflow_nxt = r_overflow;
      w_we           = 1'b0;
      if (abort) begin
         w_state_nxt = S_IDLE;
         w_count_nxt = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (arm) begin
                  w_state_nxt    = S_ARMED;
                  w_wr_ptr_nxt   = '0;
                  w_count_nxt    = '0;
                  w_post_nxt     = '0;
                  w_overflow_nxt = 1'b0;
               end
            end
            S_ARMED, S_POST: begin
               if (in_valid) begin
                  w_we         = rst;
                  w_wr_ptr_nxt = r_wr_ptr + AW'(1);
                  if (r_count < CW'(DEPTH))
                     w_count_nxt = r_count + CW'(1);
                  else
                     w_overflow_nxt = 1'b1;   // ring full: oldest entry overwritten
                  // Full in one-shot mode outranks a same-cycle trigger.
                  if (w_fills) begin
                     w_state_nxt = S_READOUT;
                  end else if (w_trig) begin
                     if (POST_TRIG == 0) begin
                        w_state_nxt = S_READOUT;
                     end else begin
                        w_state_nxt = S_POST;
                        w_post_nxt  = CW'(POST_TRIG);
                     end
                  end else if (r_state == S_POST) begin
                     w_post_nxt = r_post - CW'(1);
                     if (r_post == CW'(1))
                        w_state_nxt = S_READOUT;
                  end
               end
            end
            default: begin   // S_READOUT
               if (r_count == '0) begin
                  w_state_nxt = S_IDLE;
               end else if (rd_ready) begin
                  w_count_nxt = r_count - CW'(1);
                  if (r_count == CW'(1))
                     w_state_nxt = S_IDLE;
               end
            end
         endcase
      end
   end

   // Sample storage is never reset; only entries covered by count are read.
   always_ff @(posedge clk) begin
      if (w_we) begin
         r_mem_pc[r_wr_ptr]  <= in_pc;
         r_mem_alu[r_wr_ptr] <= in_alu_out;
         r_mem_op[r_wr_ptr]  <= in_alu_op;
         r_mem_br[r_wr_ptr]  <= in_branch;
      end
   end

   // Oldest entry sits count slots behind the write pointer (mod DEPTH);
   // with count == DEPTH the low bits of count are zero, giving wr_ptr itself.
   assign w_rd_idx   = r_wr_ptr - r_count[AW-1:0];
   assign w_rd_valid = (r_state == S_READOUT) && (r_count != '0);

   assign rd_valid   = w_rd_valid;
   assign rd_pc      = w_rd_valid ? r_mem_pc[w_rd_idx]  : '0;
   assign rd_alu_out = w_rd_valid ? r_mem_alu[w_rd_idx] : '0;
   assign rd_alu_op  = w_rd_valid ? r_mem_op[w_rd_idx]  : 4'd0;
   assign rd_branch  = w_rd_valid ? r_mem_br[w_rd_idx]  : 1'b0;
   assign state      = r_state;
   assign count      = r_count;
   assign overflow   = r_overflow;

endmodule

// File: tb/tb_exec_trace_buffer.sv
// tb_exec_trace_buffer
//   Three DEPTH=4 instances: u0 circular capture with one post-trigger sample,
//   u1 one-shot capture, u2 circular capture with no post-trigger samples.
//   Stimulus pushes expected read entries into a queue; a monitor pops and
//   compares on every read handshake of the selected instance.
module tb_exec_trace_buffer;

   localparam int XLEN = 32;
   localparam int CW   = 3;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] alu;
      logic [3:0]  op;
      logic        br;
   } ent_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, arm0, arm1, arm2, abort, trig_en, in_valid, in_branch, rd_ready;
   logic [31:0] trig_pc, in_pc, in_alu_out;
   logic [3:0]  in_alu_op;

   logic        rv0, rv1, rv2, rbr0, rbr1, rbr2, ovf0, ovf1, ovf2;
   logic [31:0] rpc0, rpc1, rpc2, ralu0, ralu1, ralu2;
   logic [3:0]  rop0, rop1, rop2;
   logic [1:0]  st0, st1, st2;
   logic [CW-1:0] cnt0, cnt1, cnt2;

   exec_trace_buffer #(.XLEN(XLEN), .DEPTH(4), .POST_TRIG(1), .MODE(0)) u0 (
      .clk(clk), .rst(rst), .arm(arm0), .abort(abort), .trig_en(trig_en), .trig_pc(trig_pc),
      .in_valid(in_valid), .in_pc(in_pc), .in_alu_out(in_alu_out), .in_alu_op(in_alu_op),
      .in_branch(in_branch), .rd_ready(rd_ready), .rd_valid(rv0), .rd_pc(rpc0),
      .rd_alu_out(ralu0), .rd_alu_op(rop0), .rd_branch(rbr0), .state(st0), .count(cnt0),
      .overflow(ovf0));

   exec_trace_buffer #(.XLEN(XLEN), .DEPTH(4), .POST_TRIG(1), .MODE(1)) u1 (
      .clk(clk), .rst(rst), .arm(arm1), .abort(abort), .trig_en(trig_en), .trig_pc(trig_pc),
      .in_valid(in_valid), .in_pc(in_pc), .in_alu_out(in_alu_out), .in_alu_op(in_alu_op),
      .in_branch(in_branch), .rd_ready(rd_ready), .rd_valid(rv1), .rd_pc(rpc1),
      .rd_alu_out(ralu1), .rd_alu_op(rop1), .rd_branch(rbr1), .state(st1), .count(cnt1),
      .overflow(ovf1));

   exec_trace_buffer #(.XLEN(XLEN), .DEPTH(4), .POST_TRIG(0), .MODE(0)) u2 (
      .clk(clk), .rst(rst), .arm(arm2), .abort(abort), .trig_en(trig_en), .trig_pc(trig_pc),
      .in_valid(in_valid), .in_pc(in_pc), .in_alu_out(in_alu_out), .in_alu_op(in_alu_op),
      .in_branch(in_branch), .rd_ready(rd_ready), .rd_valid(rv2), .rd_pc(rpc2),
      .rd_alu_out(ralu2), .rd_alu_op(rop2), .rd_branch(rbr2), .state(st2), .count(cnt2),
      .overflow(ovf2));

   int   n_chk  = 0;
   int   n_fail = 0;
   int   sel    = 0;
   ent_t exp_q[$];

   logic m_v;
   ent_t m_e;
   always_comb begin
      m_v = 1'b0;
      m_e = '0;
      case (sel)
         0: begin m_v = rv0; m_e = {rpc0, ralu0, rop0, rbr0}; end
         1: begin m_v = rv1; m_e = {rpc1, ralu1, rop1, rbr1}; end
         default: begin m_v = rv2; m_e = {rpc2, ralu2, rop2, rbr2}; end
      endcase
   end

   // Monitor: every read handshake of the selected instance must match the queue head.
   initial begin
      ent_t e;
      forever begin
         @(negedge clk);
         if (m_v && rd_ready) begin
            n_chk++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL read_unexpected: got pc 0x%0h, required no entry", m_e.pc);
            end else begin
               e = exp_q.pop_front();
               if (m_e !== e) begin
                  n_fail++;
                  $display("FAIL read_entry: got pc 0x%0h alu 0x%0h op %0d br %0d, required pc 0x%0h alu 0x%0h op %0d br %0d",
                           m_e.pc, m_e.alu, m_e.op, m_e.br, e.pc, e.alu, e.op, e.br);
               end
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic ent_t mk(input logic [31:0] pc);
      mk = {pc, pc + 32'h100, pc[5:2], pc[2]};
   endfunction

   task automatic drive(input logic [31:0] pc);
      ent_t e;
      e          = mk(pc);
      in_valid   = 1'b1;
      in_pc      = e.pc;
      in_alu_out = e.alu;
      in_alu_op  = e.op;
      in_branch  = e.br;
   endtask

   initial begin
      rst = 1'b0; arm0 = 1'b0; arm1 = 1'b0; arm2 = 1'b0; abort = 1'b0;
      trig_en = 1'b0; trig_pc = '0; in_valid = 1'b0; in_pc = '0; in_alu_out = '0;
      in_alu_op = '0; in_branch = 1'b0; rd_ready = 1'b0;

      // Reset held two cycles with arm asserted: arm must be ignored.
      arm0 = 1'b1;
      tick(); tick();
      chk("rst_state",    64'(st0),  64'd0);
      chk("rst_count",    64'(cnt0), 64'd0);
      chk("rst_rd_valid", 64'(rv0),  64'd0);
      chk("rst_overflow", 64'(ovf0), 64'd0);
      rst = 1'b1;

      // Circular capture, trigger at 0x18, one post sample, ring wraps.
      sel = 0; trig_en = 1'b1; trig_pc = 32'h18;
      tick(); arm0 = 1'b0;
      chk("m0_armed", 64'(st0), 64'd1);
      for (int pc = 0; pc <= 32'h1C; pc += 4) begin
         drive(32'(pc));
         tick();
         if (pc == 32'h14) chk("m0_still_armed", 64'(st0), 64'd1);
         if (pc == 32'h18) chk("m0_post", 64'(st0), 64'd2);
      end
      in_valid = 1'b0;
      chk("m0_readout", 64'(st0),  64'd3);
      chk("m0_count",   64'(cnt0), 64'd4);
      chk("m0_overflow",64'(ovf0), 64'd1);
      exp_q.push_back(mk(32'h10)); exp_q.push_back(mk(32'h14));
      exp_q.push_back(mk(32'h18)); exp_q.push_back(mk(32'h1C));
      rd_ready = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      rd_ready = 1'b0;
      chk("m0_idle",       64'(st0),  64'd0);
      chk("m0_drained",    64'(cnt0), 64'd0);
      chk("m0_rd_valid0",  64'(rv0),  64'd0);
      chk("m0_q_empty",    64'(exp_q.size()), 64'd0);

      // One-shot capture, trigger disabled; fifth sample must be dropped.
      sel = 1; trig_en = 1'b0;
      arm1 = 1'b1; tick(); arm1 = 1'b0;
      chk("m1_armed",     64'(st1),  64'd1);
      chk("m1_rd_pc_zero",64'(rpc1), 64'd0);
      for (int pc = 0; pc <= 32'h0C; pc += 4) begin
         drive(32'(pc));
         tick();
      end
      chk("m1_readout", 64'(st1),  64'd3);
      chk("m1_count",   64'(cnt1), 64'd4);
      drive(32'h10);
      tick();
      in_valid = 1'b0;
      chk("m1_count_after_extra", 64'(cnt1), 64'd4);
      chk("m1_overflow",          64'(ovf1), 64'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("m1_hold_pc",    64'(rpc1), 64'h0);
         chk("m1_hold_count", 64'(cnt1), 64'd4);
      end
      exp_q.push_back(mk(32'h00)); exp_q.push_back(mk(32'h04));
      exp_q.push_back(mk(32'h08)); exp_q.push_back(mk(32'h0C));
      rd_ready = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      rd_ready = 1'b0;
      chk("m1_idle",    64'(st1), 64'd0);
      chk("m1_q_empty", 64'(exp_q.size()), 64'd0);

      // Abort while in POST.
      sel = 0; trig_en = 1'b1; trig_pc = 32'h20;
      arm0 = 1'b1; tick(); arm0 = 1'b0;
      drive(32'h20);
      tick();
      in_valid = 1'b0;
      chk("ab_post",  64'(st0),  64'd2);
      chk("ab_count", 64'(cnt0), 64'd1);
      abort = 1'b1; tick(); abort = 1'b0;
      chk("ab_state",    64'(st0),  64'd0);
      chk("ab_count0",   64'(cnt0), 64'd0);
      chk("ab_rd_valid", 64'(rv0),  64'd0);

      // No post samples: trigger on the very first sample goes straight to readout.
      sel = 2; trig_pc = 32'h40;
      arm2 = 1'b1; tick(); arm2 = 1'b0;
      in_valid = 1'b1; in_pc = 32'h40; in_alu_out = 32'd7; in_alu_op = 4'd3; in_branch = 1'b1;
      exp_q.push_back({32'h40, 32'd7, 4'd3, 1'b1});
      tick();
      in_valid = 1'b0;
      chk("pt0_readout", 64'(st2),   64'd3);
      chk("pt0_count",   64'(cnt2),  64'd1);
      chk("pt0_rd_pc",   64'(rpc2),  64'h40);
      chk("pt0_rd_alu",  64'(ralu2), 64'd7);
      rd_ready = 1'b1; tick(); rd_ready = 1'b0;
      chk("pt0_idle",       64'(st2),  64'd0);
      chk("pt0_rd_pc_zero", 64'(rpc2), 64'd0);
      chk("pt0_q_empty",    64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/exec_trace_buffer.md
EXEC_TRACE_BUFFER -- requirements
Module: exec_trace_buffer

Interface
REQ-001 SHALL have parameter XLEN, default 32, width of captured PC and ALU result.
REQ-002 SHALL have parameter DEPTH, default 16, entry count; power of two, >=2.
REQ-003 SHALL have parameter POST_TRIG, default 4, samples captured after trigger sample; range 0..DEPTH-1.
REQ-004 SHALL have parameter MODE, default 0; 0 = circular capture until trigger, 1 = one-shot stop when full.
REQ-005 SHALL use derived CW = clog2(DEPTH)+1 for count width.
REQ-006 clk  in  1  clock; all state changes on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-low.
REQ-008 arm  in  1  start capture; honoured only in IDLE.
REQ-009 abort  in  1  return to IDLE from any state.
REQ-010 trig_en  in  1  enable PC-match trigger.
REQ-011 trig_pc  in  XLEN  trigger PC.
REQ-012 in_valid  in  1  sample qualifier (one retired instruction).
REQ-013 in_pc / in_alu_out  in  XLEN each  sample PC, ALU result.
REQ-014 in_alu_op  in  4  ALU opcode; in_branch  in  1  branch taken.
REQ-015 rd_ready  in  1  consumer accepts current entry.
REQ-016 rd_valid  out  1  entry presented.
REQ-017 rd_pc / rd_alu_out  out  XLEN; rd_alu_op  out  4; rd_branch  out  1  entry fields.
REQ-018 state  out  2  0 IDLE, 1 ARMED, 2 POST, 3 READOUT.
REQ-019 count  out  CW  stored entries, 0..DEPTH.
REQ-020 overflow  out  1  at least one entry overwritten this capture.

Function
REQ-021 IDLE: no writes; arm -> ARMED next cycle, clearing write pointer, count, overflow.
REQ-022 ARMED/POST: each in_valid cycle writes {pc,alu_out,alu_op,branch} at write pointer, pointer increments mod DEPTH.
REQ-023 Write with count<DEPTH increments count; count==DEPTH in MODE 0 overwrites oldest, count holds, overflow<=1.
REQ-024 MODE 1: write making count==DEPTH moves to READOUT next cycle; no further writes.
REQ-025 Trigger = ARMED & trig_en & in_valid & in_pc==trig_pc; triggering sample is stored.
REQ-026 On trigger: POST_TRIG==0 -> READOUT; else -> POST with post counter = POST_TRIG.
REQ-027 POST: each stored sample decrements post counter; reaching 0 -> READOUT next cycle.
REQ-028 PC matches in POST are not re-triggers.
REQ-029 Trigger and MODE-1 full same cycle: READOUT (full wins), post samples dropped.
REQ-030 READOUT: rd_valid = (count!=0); entry = oldest, index (wr_ptr - count) mod DEPTH, combinational from storage.
REQ-031 rd_valid & rd_ready: count decrements, next-oldest presented next cycle; rd_ready=0 holds outputs stable.
REQ-032 count reaching 0 in READOUT -> IDLE next cycle; READOUT with count 0 on entry -> IDLE.
REQ-033 rd_* data fields SHALL drive 0 whenever rd_valid=0.
REQ-034 abort has priority over arm, trigger, writes and reads: next cycle state IDLE, count 0, rd_valid 0; overflow retained.
REQ-035 in_valid and arm outside their honoured states SHALL be ignored without side effect.

Reset
REQ-036 rst=0 at edge: state IDLE, count 0, overflow 0, rd_valid 0, pointers and post counter 0; storage not cleared.
REQ-037 rst has priority over abort and all other inputs.

Verification (DEPTH=4, POST_TRIG=1 unless noted)
REQ-038 rst=0 two cycles, arm=1 -> state=0, count=0, rd_valid=0, overflow=0.
REQ-039 MODE 0, arm, trig_pc=0x18, samples pc 0x00..0x1C step 4 -> READOUT, rd_pc 0x10,0x14,0x18,0x1C, overflow=1, then IDLE.
REQ-040 MODE 1, trig_en=0, pc 0x00..0x10 -> READOUT after 4th, 0x10 not stored, rd_pc 0x00..0x0C, overflow=0.
REQ-041 READOUT, rd_ready=0 three cycles -> rd_pc, count unchanged; rd_ready=1 -> one entry per cycle.
REQ-042 abort during POST -> next cycle state=0, count=0, rd_valid=0.
REQ-043 POST_TRIG=0, trigger on first sample pc 0x40, alu_out 7 -> READOUT, count=1, rd_pc=0x40, rd_alu_out=7.
